// File: rtl/_progmem_loader.sv
// Program-memory loader: parses a framed byte stream and writes 16-bit words into program RAM.
// Define PROGMEM_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module _progmem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT_HI  = 3'd1,
    ST_CNT_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  localparam logic [7:0]  SYNC_C  = 8'hA5;
  localparam logic [16:0] DEPTH_C = 17'(DEPTH);
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHECK;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t              state_q, state_d;
  logic [7:0]          cnt_hi_q, cnt_hi_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         idx_q, idx_d;
  logic [7:0]          hi_byte_q, hi_byte_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  logic        accept_s;
  logic        is_sync_s;
  logic [15:0] count_s;
  logic        too_big_s;
  logic        last_word_s;

  // The loader never back-pressures; it is ready exactly while out of reset.
  assign in_ready    = n_reset;
  assign accept_s    = in_valid & in_ready;
  assign is_sync_s   = (in_data == SYNC_C);
  assign count_s     = {cnt_hi_q, in_data};
  assign too_big_s   = ({1'b0, count_s} > DEPTH_C);
  assign last_word_s = ((idx_q + 16'd1) == count_q);

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the FSM only moves on an accepted byte.
  always_comb begin
    state_d = state_q;
    if (accept_s) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (is_sync_s) begin
            state_d = ST_CNT_HI;
          end else begin
            state_d = state_q;
          end
        end
        ST_CNT_HI: state_d = ST_CNT_LO;
        ST_CNT_LO: begin
          if (too_big_s) begin
            state_d = ST_ERROR;
          end else if (count_s == 16'd0) begin
            state_d = ST_AFTER_DATA;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: state_d = ST_DATA_LO;
        ST_DATA_LO: begin
          if (last_word_s) begin
            state_d = ST_AFTER_DATA;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
`ifdef PROGMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (in_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output and datapath next-state logic; status flags follow the state being entered.
  always_comb begin
    cnt_hi_d     = cnt_hi_q;
    count_d      = count_q;
    idx_d        = idx_q;
    hi_byte_d    = hi_byte_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if ((state_d == ST_CNT_HI) && (state_q != ST_CNT_HI)) begin
      cpu_hold_d   = 1'b1;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
    end else if (state_d == ST_DONE) begin
      load_done_d = 1'b1;
      cpu_hold_d  = 1'b0;
    end else if (state_d == ST_ERROR) begin
      load_error_d = 1'b1;
    end else begin
      cpu_hold_d = cpu_hold_q;
    end

    if (accept_s) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (is_sync_s) begin
            idx_d = 16'd0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
            csum_d = 8'h00;
`endif
          end else begin
            idx_d = idx_q;
          end
        end
        ST_CNT_HI: begin
          cnt_hi_d = in_data;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          csum_d = csum_step(csum_q, in_data);
`endif
        end
        ST_CNT_LO: begin
          count_d = count_s;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          csum_d = csum_step(csum_q, in_data);
`endif
        end
        ST_DATA_HI: begin
          hi_byte_d = in_data;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          csum_d = csum_step(csum_q, in_data);
`endif
        end
        ST_DATA_LO: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = {hi_byte_q, in_data};
          idx_d     = idx_q + 16'd1;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
          csum_d = csum_step(csum_q, in_data);
`endif
        end
        default: begin
          idx_d = idx_q;
        end
      endcase
    end else begin
      idx_d = idx_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_hi_q     <= 8'h00;
      count_q      <= 16'd0;
      idx_q        <= 16'd0;
      hi_byte_q    <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 16'h0000;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      cnt_hi_q     <= cnt_hi_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      hi_byte_q    <= hi_byte_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb__progmem_loader.sv
// Self-checking bench for _progmem_loader: frame-level model plus a per-cycle compare process.
module tb__progmem_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  _progmem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_reset(n_reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: expected flags and the writes expected in the current cycle.
  logic        exp_hold = 1'b1;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  int          exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [15:0] img [0:127];
  logic [15:0] mem_seen [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(n_reset));
    chk("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
    chk("load_done", 32'(load_done), 32'(exp_done));
    chk("load_error", 32'(load_error), 32'(exp_err));
    chk("wr_en", 32'(wr_en), 32'(exp_addr_q.size() != 0));
    if (exp_addr_q.size() != 0) begin
      if (wr_en) begin
        chk("wr_addr", 32'(wr_addr), 32'(exp_addr_q[0]));
        chk("wr_data", 32'(wr_data), 32'(exp_data_q[0]));
      end
      void'(exp_addr_q.pop_front());
      void'(exp_data_q.pop_front());
    end
    if (wr_en) mem_seen[wr_addr] = wr_data;
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  // Sends a frame from img[]; cut stops after that many bytes, csum_o is the checksum byte used.
  task automatic send_frame(input int cnt, input bit bad_csum, input bit gap,
                            input bit skip_sync, input int cut, output logic [7:0] csum_o);
    logic [7:0]  cs;
    logic [15:0] c16;
    int          nb;
    cs  = 8'h00;
    nb  = 0;
    c16 = 16'(cnt);
    csum_o = 8'h00;
    if (!skip_sync) begin
      send_byte(8'hA5, gap);
      exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
      nb++;
      if (nb == cut) return;
    end
    send_byte(c16[15:8], gap); cs = cs ^ c16[15:8]; nb++;
    if (nb == cut) return;
    send_byte(c16[7:0], gap); cs = cs ^ c16[7:0]; nb++;
    if (cnt > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
`ifndef PROGMEM_LOADER_CHECKSUM_EN
    if (cnt == 0) begin exp_done = 1'b1; exp_hold = 1'b0; end
`endif
    if (nb == cut) return;
    for (int i = 0; i < cnt; i++) begin
      send_byte(img[i][15:8], gap); cs = cs ^ img[i][15:8]; nb++;
      if (nb == cut) return;
      send_byte(img[i][7:0], gap); cs = cs ^ img[i][7:0]; nb++;
      exp_addr_q.push_back(i);
      exp_data_q.push_back(img[i]);
`ifndef PROGMEM_LOADER_CHECKSUM_EN
      if (i == cnt - 1) begin exp_done = 1'b1; exp_hold = 1'b0; end
`endif
      if (nb == cut) return;
    end
    csum_o = bad_csum ? (cs ^ 8'h01) : cs;
`ifdef PROGMEM_LOADER_CHECKSUM_EN
    send_byte(csum_o, gap);
    if (bad_csum) exp_err = 1'b1;
    else begin exp_done = 1'b1; exp_hold = 1'b0; end
`endif
  endtask

  initial begin
    logic [7:0] cs;
    for (int i = 0; i < 64; i++) mem_seen[i] = 16'hDEAD;
    for (int i = 0; i < 128; i++) img[i] = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    n_reset = 1'b1;
    @(posedge clk); #1;

    // 1: valid load A5 00 03 0000 8FC8 0002 [46]
    img[0] = 16'h0000; img[1] = 16'h8FC8; img[2] = 16'h0002;
    send_frame(3, 1'b0, 1'b0, 1'b0, -1, cs);
    chk("t1_csum_byte", 32'(cs), 32'h46);
    chk("t1_load_done", 32'(load_done), 32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk); #1;
    chk("t1_mem0", 32'(mem_seen[0]), 32'h0000);
    chk("t1_mem1", 32'(mem_seen[1]), 32'h8FC8);
    chk("t1_mem2", 32'(mem_seen[2]), 32'h0002);

`ifdef PROGMEM_LOADER_CHECKSUM_EN
    // 2: bad checksum
    send_frame(3, 1'b1, 1'b0, 1'b0, -1, cs);
    chk("t2_bad_byte", 32'(cs), 32'h47);
    chk("t2_load_error", 32'(load_error), 32'd1);
    chk("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t2_load_done", 32'(load_done), 32'd0);
`endif

    // 3: oversize count, then a good frame
    send_frame(65, 1'b0, 1'b0, 1'b0, -1, cs);
    chk("t3_load_error", 32'(load_error), 32'd1);
    chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    send_frame(3, 1'b0, 1'b0, 1'b0, -1, cs);
    chk("t3_reload_done", 32'(load_done), 32'd1);
    chk("t3_reload_err", 32'(load_error), 32'd0);

    // 4: garbage, gaps, empty image
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_frame(0, 1'b0, 1'b1, 1'b0, -1, cs);
    chk("t4_csum_byte", 32'(cs), 32'h00);
    chk("t4_load_done", 32'(load_done), 32'd1);
    chk("t4_cpu_hold", 32'(cpu_hold), 32'd0);

    // 5: reset after A5 00 02 00 00 8F
    img[0] = 16'h0000; img[1] = 16'h8FC8;
    send_frame(2, 1'b0, 1'b0, 1'b0, 6, cs);
    n_reset = 1'b0;
    exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    #1;
    chk("t5_wr_en", 32'(wr_en), 32'd0);
    chk("t5_wr_addr", 32'(wr_addr), 32'd0);
    chk("t5_wr_data", 32'(wr_data), 32'd0);
    chk("t5_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h5555;
    send_frame(3, 1'b0, 1'b0, 1'b0, -1, cs);
    chk("t5_load_done", 32'(load_done), 32'd1);
    @(negedge clk); #1;
    chk("t5_mem0", 32'(mem_seen[0]), 32'h1234);
    chk("t5_mem2", 32'(mem_seen[2]), 32'h5555);

    // 6: reload after DONE
    send_byte(8'hA5, 1'b0);
    exp_hold = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    chk("t6_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t6_load_done", 32'(load_done), 32'd0);
    img[0] = 16'hCAFE; img[1] = 16'h0BAD;
    send_frame(2, 1'b0, 1'b0, 1'b1, -1, cs);
    chk("t6_done_again", 32'(load_done), 32'd1);
    @(negedge clk); #1;
    chk("t6_mem0", 32'(mem_seen[0]), 32'hCAFE);
    chk("t6_mem1", 32'(mem_seen[1]), 32'h0BAD);
    chk("t6_mem2_kept", 32'(mem_seen[2]), 32'h5555);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
